decode_issue_queue: RTL and testbench



---
 rtl/decode_issue_queue_if.sv | 41 ++++
 rtl/decode_issue_queue.sv | 87 ++++++++
 tb/tb_decode_issue_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/decode_issue_queue_if.sv
// Handshake bundle between decode, the decode/issue queue and issue.
//
// Item layout (50 bits, queue_item_t as packed by decode, MSB first):
//   [49:43] uopcode    [42:40] exu_type   [39] has_rd  [38] has_rs1
//   [37]    has_rs2    [36:32] rd         [31:27] rs1  [26:22] rs2
//   [21:19] imm_type   [18:2]  packed_imm [1] taken    [0] shadowed
// The queue never looks inside an item. The layout is listed only so that
// anyone probing waveforms can find the fields.
//
// Signals:
//   flush                       redirect, discard every queued entry
//   enq_valid/enq_ready/enq_item   decode -> queue
//   deq_valid/deq_ready/deq_item   queue -> issue
//   count/almost_full/empty        occupancy status back to decode
// Modports: slave = the queue itself, master = the decode/issue side.
interface decode_issue_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [49:0]   enq_item;
  logic          deq_valid;
  logic          deq_ready;
  logic [49:0]   deq_item;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          empty;

  modport slave (
    input  flush, enq_valid, enq_item, deq_ready,
    output enq_ready, deq_valid, deq_item, count, almost_full, empty
  );

  modport master (
    output flush, enq_valid, enq_item, deq_ready,
    input  enq_ready, deq_valid, deq_item, count, almost_full, empty
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular in-order FIFO between instruction decode and issue.
//
// Decode pushes 50-bit queue items. Issue pops them in program order. The
// queue absorbs stalls on either side. A flush, such as a branch mispredict,
// empties it in one cycle.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   q    decode_issue_queue_if.slave, which carries flush, the enq/deq
//        handshakes, and the count/almost_full/empty status
//
// Parameters:
//   DEPTH      number of entries; must be a power of two and at least 2
//   AF_THRESH  almost_full asserts when count >= AF_THRESH (1..DEPTH)
module decode_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_issue_queue_if.slave  q
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Each pointer has one extra wrap bit. Equal pointers mean empty. When the
  // index bits match and the wrap bits differ, the queue is full.
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [49:0]   mem_reg [DEPTH];

  logic [IW-1:0] head_idx, tail_idx;
  logic [PW-1:0] count_w;
  logic          full_w, empty_w;
  logic          enq_fire, deq_fire;

  assign head_idx = head_reg[IW-1:0];
  assign tail_idx = tail_reg[IW-1:0];
  assign empty_w  = (head_reg == tail_reg);
  assign full_w   = (head_idx == tail_idx) && (head_reg[IW] != tail_reg[IW]);
  // The subtraction is modular, so the wrap bit gives the right count across
  // the pointer rollover.
  assign count_w  = tail_reg - head_reg;

  // enq_ready looks only at registered state and flush. A full queue never
  // accepts an item, even when issue drains one in the same cycle.
  assign q.enq_ready   = !full_w && !q.flush;
  assign q.deq_valid   = !empty_w;
  assign q.deq_item    = mem_reg[head_idx];
  assign q.count       = count_w;
  assign q.empty       = empty_w;
  assign q.almost_full = (count_w >= PW'(AF_THRESH));

  assign enq_fire = q.enq_valid && q.enq_ready;
  assign deq_fire = q.deq_valid && q.deq_ready && !q.flush;

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (q.flush) begin
      head_next = '0;
      tail_next = '0;
    end else begin
      if (enq_fire) tail_next = tail_reg + PW'(1);
      if (deq_fire) head_next = head_reg + PW'(1);
    end
  end

  // rst takes priority over flush. Both put the pointers back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // The storage is not reset. A slot is only read after a write has filled it.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) mem_reg[tail_idx] <= q.enq_item;
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue. The bench runs directed scenarios
// and then a randomized phase. A plain SystemVerilog queue serves as the
// reference model.
module tb_decode_issue_queue;

  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_queue_if #(.DEPTH(DEPTH)) ifc ();

  decode_issue_queue #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [49:0] mq[$];   // reference model: items in program order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] make_item(input logic [16:0] imm, input logic tk, input logic sh);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {r[49:19], imm, tk, sh};
  endfunction

  // Run one clock. The task drives the inputs, checks the combinational
  // outputs before the edge, updates the model, and then checks the
  // registered state after the edge.
  task automatic cycle(input logic r, input logic f, input logic ev,
                       input logic [49:0] it, input logic dr);
    bit ef, df;
    rst           = r;
    ifc.flush     = f;
    ifc.enq_valid = ev;
    ifc.enq_item  = it;
    ifc.deq_ready = dr;
    #3;
    if (!r) begin
      chk("pre_enq_ready", 64'(ifc.enq_ready), 64'((mq.size() < DEPTH) && !f));
      chk("pre_deq_valid", 64'(ifc.deq_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("pre_deq_item", 64'(ifc.deq_item), 64'(mq[0]));
    end
    ef = ev && (mq.size() < DEPTH) && !f;
    df = dr && (mq.size() > 0) && !f;
    @(posedge clk);
    #1;
    if (r || f) mq.delete();
    else begin
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back(it);
    end
    chk("count", 64'(ifc.count), 64'(mq.size()));
    chk("count_le_depth", 64'(ifc.count <= DEPTH), 64'(1));
    chk("empty", 64'(ifc.empty), 64'(mq.size() == 0));
    chk("almost_full", 64'(ifc.almost_full), 64'(mq.size() >= AF_THRESH));
    chk("deq_valid", 64'(ifc.deq_valid), 64'(mq.size() > 0));
    chk("enq_ready", 64'(ifc.enq_ready), 64'((mq.size() < DEPTH) && !f));
    if (mq.size() > 0) chk("deq_item", 64'(ifc.deq_item), 64'(mq[0]));
  endtask

  initial begin
    logic [49:0] x, y, z;
    ifc.flush = 1'b0; ifc.enq_valid = 1'b0; ifc.enq_item = '0; ifc.deq_ready = 1'b0;

    // Reset
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_count", 64'(ifc.count), 64'(0));
    chk("rst_enq_ready", 64'(ifc.enq_ready), 64'(1));

    // Fill with packed_imm = 1..8. The 9th item is refused.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, make_item(17'(i), 1'b0, 1'b0), 1'b0);
      chk("fill_af", 64'(ifc.almost_full), 64'(i >= AF_THRESH));
    end
    chk("full_count", 64'(ifc.count), 64'(DEPTH));
    chk("full_enq_ready", 64'(ifc.enq_ready), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, make_item(17'd9, 1'b0, 1'b0), 1'b0);
    chk("ninth_refused", 64'(ifc.count), 64'(DEPTH));

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_imm", 64'(ifc.deq_item[18:2]), 64'(i));
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    chk("drained_empty", 64'(ifc.empty), 64'(1));

    // Preload 3 items, then stream for 20 cycles so the pointers wrap
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, make_item(17'(100 + i), 1'b0, 1'b0), 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("stream_imm", 64'(ifc.deq_item[18:2]), 64'(100 + i));
      cycle(1'b0, 1'b0, 1'b1, make_item(17'(103 + i), 1'b1, 1'b0), 1'b1);
    end
    chk("stream_count", 64'(ifc.count), 64'(3));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Latency: the item shows at the output only after the enqueue edge
    x = make_item(17'h1abcd, 1'b1, 1'b1);
    chk("lat_before", 64'(ifc.deq_valid), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, x, 1'b0);
    chk("lat_after_valid", 64'(ifc.deq_valid), 64'(1));
    chk("lat_after_item", 64'(ifc.deq_item), 64'(x));
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Flush with an enqueue and a dequeue in the same cycle, at count = 5
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, make_item(17'(200 + i), 1'b0, 1'b0), 1'b0);
    y = make_item(17'h0dead, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, y, 1'b1);
    ifc.flush = 1'b0;
    #1;
    chk("flush_count", 64'(ifc.count), 64'(0));
    chk("flush_enq_ready", 64'(ifc.enq_ready), 64'(1));
    z = make_item(17'h00123, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, z, 1'b0);
    chk("post_flush_item", 64'(ifc.deq_item), 64'(z));
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // rst and flush together in mid-stream with an enqueue
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, make_item(17'(300 + i), 1'b0, 1'b0), 1'b1);
    cycle(1'b1, 1'b1, 1'b1, make_item(17'h1ffff, 1'b1, 1'b1), 1'b1);
    chk("rstflush_count", 64'(ifc.count), 64'(0));
    x = make_item(17'h15555, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, x, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, make_item(17'h0aaaa, 1'b0, 1'b0), 1'b0);
    chk("rst_first_item", 64'(ifc.deq_item), 64'(x));
    chk("rst_first_tk_sh", 64'(ifc.deq_item[1:0]), 64'(2'b11));

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0 || ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) != 0),
            make_item(17'($urandom()), 1'($urandom()), 1'($urandom())),
            ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
